// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bit positions inside the ctlwb/ctlm bundles
// and the memory-access state encoding used by mem_stage and dmem_handshake.
package pipe_pkg;

  localparam int CTLWB_REGWRITE = 1;
  localparam int CTLWB_MEMTOREG = 0;

  localparam int CTLM_BRANCH   = 2;
  localparam int CTLM_MEMREAD  = 1;
  localparam int CTLM_MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// Handshake: req rises with addr/we/wdata valid and holds them stable until the
// slave answers with a one-cycle ack; rdata is valid in the ack cycle only.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// IDLE/WAIT controller for one outstanding data-memory access.
// req and stall are decoded from the state only, so reset drops them at once.
module dmem_handshake
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  output logic       req,
  output logic       stall,
  output logic       done,
  output mem_state_t state
);

  mem_state_t state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM boundary, data-memory access and MEM/WB register of the pipeline.
// Optional misaligned-access trap is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [1:0]            ctlwb_in,
  input  logic [2:0]            ctlm_in,
  input  logic [DATA_W-1:0]     adder_in,
  input  logic                  aluzero_in,
  input  logic [DATA_W-1:0]     aluout_in,
  input  logic [DATA_W-1:0]     readdat2_in,
  input  logic [REG_ADDR_W-1:0] muxout_in,
  output logic                  stall,
  mem_stage_if.master           dmem,
  output logic                  pcsrc,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  memwb_valid,
  output logic [1:0]            memwb_ctlwb,
  output logic [DATA_W-1:0]     memwb_rdata,
  output logic [DATA_W-1:0]     memwb_aluout,
  output logic [REG_ADDR_W-1:0] memwb_rd,
  output logic                  align_err,
  output mem_state_t            dbg_state
);

  mem_state_t              state;
  logic                    req;
  logic                    done;
  logic                    accept;
  logic                    is_mem;
  logic                    misaligned;
  logic                    start;
  logic                    direct;
  logic                    kill_now;
  logic [1:0]              ctlwb_direct;

  logic [DATA_W-1:0]       reg_addr;
  logic [DATA_W-1:0]       reg_wdata;
  logic                    reg_we;
  logic                    reg_load;
  logic [1:0]              reg_ctlwb;
  logic [REG_ADDR_W-1:0]   reg_rd;
  logic                    reg_kill;

  assign accept = in_valid & ~flush & (state == IDLE);
  assign is_mem = ctlm_in[CTLM_MEMREAD] | ctlm_in[CTLM_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = accept & is_mem & (aluout_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Misaligned accesses never reach the bus; they retire straight away.
  assign start  = accept & is_mem & ~misaligned;
  assign direct = accept & (~is_mem | misaligned);

  always_comb begin
    ctlwb_direct = ctlwb_in;
    if (misaligned) begin
      ctlwb_direct[CTLWB_REGWRITE] = 1'b0;
    end
  end

  dmem_handshake u_handshake (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ack   (dmem.ack),
    .req   (req),
    .stall (stall),
    .done  (done),
    .state (state)
  );

  assign dbg_state  = state;
  assign dmem.req   = req;
  assign dmem.we    = reg_we;
  assign dmem.addr  = reg_addr;
  assign dmem.wdata = reg_wdata;

  // A flush seen at any point of WAIT, including the ack cycle, drops the writeback.
  assign kill_now = reg_kill | flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_load  <= 1'b0;
      reg_ctlwb <= '0;
      reg_rd    <= '0;
      reg_kill  <= 1'b0;
    end else if (start) begin
      reg_addr  <= aluout_in;
      reg_wdata <= readdat2_in;
      reg_we    <= ctlm_in[CTLM_MEMWRITE];
      reg_load  <= ctlm_in[CTLM_MEMREAD] & ~ctlm_in[CTLM_MEMWRITE];
      reg_ctlwb <= ctlwb_in;
      reg_rd    <= muxout_in;
      reg_kill  <= 1'b0;
    end else if ((state == WAIT) && flush) begin
      reg_kill  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memwb_valid  <= 1'b0;
      memwb_ctlwb  <= '0;
      memwb_rdata  <= '0;
      memwb_aluout <= '0;
      memwb_rd     <= '0;
    end else begin
      memwb_valid <= 1'b0;
      if (direct) begin
        memwb_valid  <= 1'b1;
        memwb_ctlwb  <= ctlwb_direct;
        memwb_aluout <= aluout_in;
        memwb_rd     <= muxout_in;
      end else if (done && !kill_now) begin
        memwb_valid  <= 1'b1;
        memwb_ctlwb  <= reg_ctlwb;
        memwb_aluout <= reg_addr;
        memwb_rd     <= reg_rd;
        if (reg_load) begin
          memwb_rdata <= dmem.rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsrc         <= 1'b0;
      branch_target <= '0;
    end else begin
      pcsrc <= accept & ctlm_in[CTLM_BRANCH] & aluzero_in;
      if (accept) begin
        branch_target <= adder_in;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else begin
      align_err <= misaligned;
    end
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model with a memory image.
module tb_mem_stage;
  import pipe_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REC_W      = 2 + DATA_W + DATA_W + REG_ADDR_W;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  flush = 1'b0;
  logic [1:0]            ctlwb_in = '0;
  logic [2:0]            ctlm_in = '0;
  logic [DATA_W-1:0]     adder_in = '0;
  logic                  aluzero_in = 1'b0;
  logic [DATA_W-1:0]     aluout_in = '0;
  logic [DATA_W-1:0]     readdat2_in = '0;
  logic [REG_ADDR_W-1:0] muxout_in = '0;
  logic                  stall;
  logic                  pcsrc;
  logic [DATA_W-1:0]     branch_target;
  logic                  memwb_valid;
  logic [1:0]            memwb_ctlwb;
  logic [DATA_W-1:0]     memwb_rdata;
  logic [DATA_W-1:0]     memwb_aluout;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic                  align_err;
  mem_state_t            dbg_state;

  int checks = 0;
  int failures = 0;

  logic [REC_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] mem_img[int];
  logic [DATA_W-1:0] last_rdata = '0;

  mem_stage_if #(.DATA_W(DATA_W)) dmem ();

  mem_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .flush         (flush),
    .ctlwb_in      (ctlwb_in),
    .ctlm_in       (ctlm_in),
    .adder_in      (adder_in),
    .aluzero_in    (aluzero_in),
    .aluout_in     (aluout_in),
    .readdat2_in   (readdat2_in),
    .muxout_in     (muxout_in),
    .stall         (stall),
    .dmem          (dmem.master),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .memwb_valid   (memwb_valid),
    .memwb_ctlwb   (memwb_ctlwb),
    .memwb_rdata   (memwb_rdata),
    .memwb_aluout  (memwb_aluout),
    .memwb_rd      (memwb_rd),
    .align_err     (align_err),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic [1:0] wb, input logic [2:0] m, input logic [DATA_W-1:0] alu,
                             input logic [DATA_W-1:0] wd, input logic [REG_ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] tgt, input logic zero);
    in_valid    = 1'b1;
    ctlwb_in    = wb;
    ctlm_in     = m;
    aluout_in   = alu;
    readdat2_in = wd;
    muxout_in   = rd;
    adder_in    = tgt;
    aluzero_in  = zero;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    ctlm_in  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem.req); end
    checks++; if (memwb_valid !== 1'b0) begin failures++; $display("FAIL reset_memwb_valid got=%b exp=0", memwb_valid); end
    checks++; if (pcsrc !== 1'b0) begin failures++; $display("FAIL reset_pcsrc got=%b exp=0", pcsrc); end
    checks++; if ({memwb_ctlwb, memwb_rdata, memwb_aluout, memwb_rd} !== '0) begin failures++; $display("FAIL reset_memwb_fields got=%h exp=0", {memwb_ctlwb, memwb_rdata, memwb_aluout, memwb_rd}); end
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL reset_align_err got=%b exp=0", align_err); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    #12 reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive_instr(2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h0, 1'b0);
    tick();
    drive_idle();
    checks++; if (memwb_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", memwb_valid); end
    checks++; if (memwb_aluout !== 32'h1234) begin failures++; $display("FAIL alu_aluout got=%h exp=00001234", memwb_aluout); end
    checks++; if (memwb_rd !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d exp=5", memwb_rd); end
    checks++; if (memwb_ctlwb !== 2'b10) begin failures++; $display("FAIL alu_ctlwb got=%b exp=10", memwb_ctlwb); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    checks++; if (memwb_valid !== 1'b0) begin failures++; $display("FAIL alu_valid_clear got=%b exp=0", memwb_valid); end
    checks++; if (memwb_aluout !== 32'h1234) begin failures++; $display("FAIL alu_aluout_hold got=%h exp=00001234", memwb_aluout); end
  endtask

  task automatic test_load();
    drive_instr(2'b11, 3'b010, 32'h40, 32'h0, 5'd7, 32'h0, 1'b0);
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem.req !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL load_req_stall cyc=%0d got=%b%b exp=11", i, dmem.req, stall); end
      checks++; if (dmem.we !== 1'b0 || dmem.addr !== 32'h40) begin failures++; $display("FAIL load_bus cyc=%0d we=%b addr=%h exp we=0 addr=00000040", i, dmem.we, dmem.addr); end
      checks++; if (memwb_valid !== 1'b0) begin failures++; $display("FAIL load_early_valid cyc=%0d got=%b exp=0", i, memwb_valid); end
      if (i == 2) begin
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hDEADBEEF;
      end
      tick();
    end
    dmem.ack = 1'b0;
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL load_release got=%b%b exp=00", dmem.req, stall); end
    checks++; if (memwb_valid !== 1'b1 || memwb_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_retire valid=%b rdata=%h exp 1 deadbeef", memwb_valid, memwb_rdata); end
    checks++; if (memwb_rd !== 5'd7 || memwb_aluout !== 32'h40 || memwb_ctlwb !== 2'b11) begin failures++; $display("FAIL load_fields rd=%0d alu=%h ctl=%b exp 7 00000040 11", memwb_rd, memwb_aluout, memwb_ctlwb); end
    last_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_store();
    drive_instr(2'b00, 3'b001, 32'h80, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0);
    tick();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      checks++; if (dmem.req !== 1'b1 || dmem.we !== 1'b1 || dmem.addr !== 32'h80 || dmem.wdata !== 32'hA5A5A5A5) begin
        failures++; $display("FAIL store_bus cyc=%0d req=%b we=%b addr=%h wdata=%h exp 1 1 00000080 a5a5a5a5", i, dmem.req, dmem.we, dmem.addr, dmem.wdata); end
      if (i == 1) begin
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h0BAD0BAD;
      end
      tick();
    end
    dmem.ack = 1'b0;
    checks++; if (memwb_valid !== 1'b1 || memwb_ctlwb[CTLWB_REGWRITE] !== 1'b0) begin failures++; $display("FAIL store_retire valid=%b ctlwb=%b exp valid=1 regwrite=0", memwb_valid, memwb_ctlwb); end
    checks++; if (memwb_rdata !== last_rdata) begin failures++; $display("FAIL store_rdata_hold got=%h exp=%h", memwb_rdata, last_rdata); end
  endtask

  task automatic test_branch();
    drive_instr(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 32'h100, 1'b1);
    tick();
    drive_idle();
    checks++; if (pcsrc !== 1'b1 || branch_target !== 32'h100) begin failures++; $display("FAIL branch_taken pcsrc=%b tgt=%h exp 1 00000100", pcsrc, branch_target); end
    tick();
    checks++; if (pcsrc !== 1'b0) begin failures++; $display("FAIL branch_pulse got=%b exp=0", pcsrc); end
    drive_instr(2'b00, 3'b100, 32'h0, 32'h0, 5'd0, 32'h200, 1'b0);
    tick();
    drive_idle();
    checks++; if (pcsrc !== 1'b0) begin failures++; $display("FAIL branch_not_taken got=%b exp=0", pcsrc); end
  endtask

  task automatic test_flush();
    drive_instr(2'b10, 3'b100, 32'h77, 32'h0, 5'd9, 32'h300, 1'b1);
    flush = 1'b1;
    tick();
    drive_idle();
    checks++; if (memwb_valid !== 1'b0 || pcsrc !== 1'b0 || dmem.req !== 1'b0) begin failures++; $display("FAIL flush_idle valid=%b pcsrc=%b req=%b exp 000", memwb_valid, pcsrc, dmem.req); end
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0;
    checks++; if (memwb_valid !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL ack_in_idle valid=%b state=%0d exp 0 IDLE", memwb_valid, dbg_state); end
    drive_instr(2'b11, 3'b010, 32'h44, 32'h0, 5'd3, 32'h0, 1'b0);
    tick();
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++; if (dmem.req !== 1'b1) begin failures++; $display("FAIL flush_wait_req got=%b exp=1", dmem.req); end
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h12345678;
    tick();
    dmem.ack = 1'b0;
    checks++; if (memwb_valid !== 1'b0 || memwb_rdata !== last_rdata) begin failures++; $display("FAIL flush_wait_retire valid=%b rdata=%h exp 0 %h", memwb_valid, memwb_rdata, last_rdata); end
    checks++; if (dmem.req !== 1'b0) begin failures++; $display("FAIL flush_wait_release got=%b exp=0", dmem.req); end
    drive_instr(2'b11, 3'b010, 32'h48, 32'h0, 5'd4, 32'h0, 1'b0);
    tick();
    drive_idle();
    #2 reset = 1'b0;
    #1;
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL async_reset req=%b stall=%b state=%0d exp 0 0 IDLE", dmem.req, stall, dbg_state); end
    checks++; if (memwb_rdata !== '0) begin failures++; $display("FAIL async_reset_rdata got=%h exp=0", memwb_rdata); end
    last_rdata = '0;
    #2 reset = 1'b1;
    tick();
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    drive_instr(2'b11, 3'b010, 32'h41, 32'h0, 5'd6, 32'h0, 1'b0);
    tick();
    drive_idle();
    checks++; if (dmem.req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL align_no_req req=%b stall=%b exp 0 0", dmem.req, stall); end
    checks++; if (align_err !== 1'b1 || memwb_valid !== 1'b1 || memwb_ctlwb[CTLWB_REGWRITE] !== 1'b0) begin
      failures++; $display("FAIL align_retire err=%b valid=%b ctlwb=%b exp 1 1 regwrite=0", align_err, memwb_valid, memwb_ctlwb); end
    tick();
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL align_pulse got=%b exp=0", align_err); end
  endtask
`endif

  // Transaction-level model: each accepted instruction retires once with its
  // ctlwb/aluout/rd; loads return the memory image word, flushed ones vanish.
  task automatic test_random();
    int unsigned kind, lat;
    logic fl_acc, fl_wait, is_mem, is_store, is_load, exp_pc;
    logic [1:0]            wb;
    logic [2:0]            m;
    logic [DATA_W-1:0]     addr, wd, tgt, word;
    logic [REG_ADDR_W-1:0] rd;
    logic [REC_W-1:0]      got, exp_rec;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      wb   = 2'($urandom_range(0, 3));
      m    = {1'($urandom_range(0, 1)), 2'b00};
      if (kind == 1) m[CTLM_MEMREAD] = 1'b1;
      if (kind == 2) begin m[CTLM_MEMWRITE] = 1'b1; m[CTLM_MEMREAD] = 1'($urandom_range(0, 1)); end
      addr = DATA_W'($urandom_range(0, 15)) << 2;
      wd   = $urandom;
      tgt  = $urandom;
      rd   = REG_ADDR_W'($urandom_range(0, 31));
      fl_acc   = ($urandom_range(0, 7) == 0);
      is_mem   = (kind == 1) || (kind == 2);
      is_store = (kind == 2);
      is_load  = (kind == 1);
      drive_instr(wb, m, addr, wd, rd, tgt, 1'($urandom_range(0, 1)));
      flush  = fl_acc;
      exp_pc = !fl_acc && m[CTLM_BRANCH] && aluzero_in;
      if (!fl_acc && !is_mem) exp_q.push_back({wb, last_rdata, addr, rd});
      tick();
      drive_idle();
      checks++; if (pcsrc !== exp_pc || (exp_pc && branch_target !== tgt)) begin failures++; $display("FAIL rnd_pcsrc n=%0d pcsrc=%b tgt=%h exp %b %h", n, pcsrc, branch_target, exp_pc, tgt); end
      got = {memwb_ctlwb, memwb_rdata, memwb_aluout, memwb_rd};
      checks++; if (memwb_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_valid_accept n=%0d got=%b exp=%b", n, memwb_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        exp_rec = exp_q.pop_front();
        checks++; if (got !== exp_rec) begin failures++; $display("FAIL rnd_retire_alu n=%0d got=%h exp=%h", n, got, exp_rec); end
      end
      if (is_mem && !fl_acc) begin
        lat     = $urandom_range(1, 4);
        fl_wait = ($urandom_range(0, 3) == 0);
        word    = mem_img.exists(int'(addr)) ? mem_img[int'(addr)] : DATA_W'($urandom);
        for (int i = 0; i < int'(lat); i++) begin
          checks++; if (dmem.req !== 1'b1 || stall !== 1'b1 || dmem.we !== is_store || dmem.addr !== addr || (is_store && dmem.wdata !== wd)) begin
            failures++; $display("FAIL rnd_bus n=%0d cyc=%0d req=%b stall=%b we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h", n, i, dmem.req, stall, dmem.we, dmem.addr, dmem.wdata, is_store, addr, wd); end
          // execute presents unrelated traffic while stalled; it must be ignored
          drive_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom, 5'd31, $urandom, 1'b1);
          flush = fl_wait && (i == 0);
          if (i == int'(lat) - 1) begin
            dmem.ack   = 1'b1;
            dmem.rdata = is_store ? DATA_W'($urandom) : word;
            in_valid   = 1'b0;
          end
          tick();
          flush = 1'b0;
        end
        dmem.ack = 1'b0;
        drive_idle();
        if (is_store) mem_img[int'(addr)] = wd;
        if (!fl_wait) begin
          if (is_load) last_rdata = word;
          exp_q.push_back({wb, last_rdata, addr, rd});
        end
        got = {memwb_ctlwb, memwb_rdata, memwb_aluout, memwb_rd};
        checks++; if (memwb_valid !== (exp_q.size() != 0) || stall !== 1'b0 || pcsrc !== 1'b0) begin
          failures++; $display("FAIL rnd_valid_mem n=%0d valid=%b stall=%b pcsrc=%b exp %b 0 0", n, memwb_valid, stall, pcsrc, exp_q.size() != 0); end
        if (exp_q.size() != 0) begin
          exp_rec = exp_q.pop_front();
          checks++; if (got !== exp_rec) begin failures++; $display("FAIL rnd_retire_mem n=%0d got=%h exp=%h", n, got, exp_rec); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_flush();
`ifdef MEM_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
